pipe_hazard_ctrl: RTL and testbench

Central hazard and flush controller for the five-stage RISC-V pipeline. It detects load-use hazards, instruction-memory wait states, ID-stage redirects and EX-stage branch mispredictions, and drives the front-end stall and the IF/ID and ID/EX flush/hold controls. It tracks each conditional branch's prediction from ID to EX and keeps saturating performance counters. It sits beside IF, ID and EX; its `EX_stall` output feeds the IF stage's stall input directly.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 16 +
 rtl/pipe_hazard_ctrl_if.sv | 48 ++++
 rtl/pipe_hazard_ctrl_sat_counter.sv | 27 ++
 rtl/pipe_hazard_ctrl.sv | 132 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/flush controller.
package pipe_hazard_ctrl_pkg;

  // Architectural register index width (x0..x31).
  localparam int REG_IDX_W = 5;

  // Default width of the performance counters.
  localparam int CNT_W_DEF = 32;

  // Hazard controller states.
  typedef enum logic {
    HZ_RUN      = 1'b0,
    HZ_LU_STALL = 1'b1
  } hz_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle of pipeline-facing signals of the hazard controller.
// The slave side is the controller; the master side is the pipeline.
interface pipe_hazard_ctrl_if
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);
  logic [REG_IDX_W-1:0] ID_rs1;
  logic [REG_IDX_W-1:0] ID_rs2;
  logic                 ID_rs1_used;
  logic                 ID_rs2_used;
  logic                 EX_mem_read;
  logic [REG_IDX_W-1:0] EX_rd;
  logic                 ID_branch;
  logic                 ID_unconditional_jmp;
  logic                 ID_pred_take;
  logic                 EX_branch;
  logic                 EX_unconditional_jmp;
  logic                 EX_zero;
  logic                 imem_ready;
  logic                 perf_clear;

  logic                 EX_stall;
  logic                 IFID_write_en;
  logic                 IFID_flush;
  logic                 IDEX_flush;
  logic                 mispredict;
  logic [CNT_W-1:0]     perf_branch_cnt;
  logic [CNT_W-1:0]     perf_mispred_cnt;
  logic [CNT_W-1:0]     perf_stall_cnt;

  modport slave (
    input  ID_rs1, ID_rs2, ID_rs1_used, ID_rs2_used, EX_mem_read, EX_rd,
           ID_branch, ID_unconditional_jmp, ID_pred_take,
           EX_branch, EX_unconditional_jmp, EX_zero, imem_ready, perf_clear,
    output EX_stall, IFID_write_en, IFID_flush, IDEX_flush, mispredict,
           perf_branch_cnt, perf_mispred_cnt, perf_stall_cnt
  );

  modport master (
    output ID_rs1, ID_rs2, ID_rs1_used, ID_rs2_used, EX_mem_read, EX_rd,
           ID_branch, ID_unconditional_jmp, ID_pred_take,
           EX_branch, EX_unconditional_jmp, EX_zero, imem_ready, perf_clear,
    input  EX_stall, IFID_write_en, IFID_flush, IDEX_flush, mispredict,
           perf_branch_cnt, perf_mispred_cnt, perf_stall_cnt
  );

endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment).
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  // Count events, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and flush controller for the five-stage pipeline: load-use
// stalls, imem wait states, ID redirects and EX branch mispredicts.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W           = CNT_W_DEF,
  parameter int LU_STALL_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  pipe_hazard_ctrl_if.slave hz
);

  // Remaining bubbles after the first one, loaded on LU_STALL entry.
  localparam logic [2:0] LU_RELOAD = 3'(LU_STALL_CYCLES - 1);

  hz_state_e  r_state;
  hz_state_e  w_state_next;
  logic [2:0] r_lu_cnt;
  logic [2:0] w_lu_cnt_next;
  logic       r_ex_valid;
  logic       r_ex_pred;

  logic w_lu_hit;
  logic w_ex_cond;
  logic w_mispredict;
  logic w_ex_stall;
  logic w_ifid_we;
  logic w_ifid_flush;
  logic w_idex_flush;

  // Hazard detection: a load in EX feeding a source read in ID.
  assign w_lu_hit = hz.EX_mem_read && (hz.EX_rd != '0) &&
                    ((hz.ID_rs1_used && (hz.ID_rs1 == hz.EX_rd)) ||
                     (hz.ID_rs2_used && (hz.ID_rs2 == hz.EX_rd)));

  // A conditional branch resolving in EX that carries a tracked prediction.
  assign w_ex_cond    = hz.EX_branch && !hz.EX_unconditional_jmp && r_ex_valid;
  assign w_mispredict = w_ex_cond && (r_ex_pred != hz.EX_zero);

  // Prioritised control decode and next-state logic.
  always_comb begin
    w_ex_stall    = 1'b0;
    w_ifid_we     = 1'b1;
    w_ifid_flush  = 1'b0;
    w_idex_flush  = 1'b0;
    w_state_next  = r_state;
    w_lu_cnt_next = r_lu_cnt;
    if (w_mispredict) begin
      // Redirect wins over every stall source; any pending stall is dropped.
      w_ifid_flush  = 1'b1;
      w_idex_flush  = 1'b1;
      w_state_next  = HZ_RUN;
      w_lu_cnt_next = '0;
    end else if (!hz.imem_ready) begin
      // Fetch not ready: hold the front end, stall bookkeeping frozen.
      w_ex_stall   = 1'b1;
      w_ifid_we    = 1'b0;
      w_idex_flush = 1'b1;
    end else if (((r_state == HZ_RUN) && w_lu_hit) || (r_state == HZ_LU_STALL)) begin
      w_ex_stall   = 1'b1;
      w_ifid_we    = 1'b0;
      w_idex_flush = 1'b1;
      if (r_state == HZ_RUN) begin
        if (LU_STALL_CYCLES > 1) begin
          w_state_next  = HZ_LU_STALL;
          w_lu_cnt_next = LU_RELOAD;
        end
      end else begin
        w_lu_cnt_next = r_lu_cnt - 3'd1;
        if (r_lu_cnt == 3'd1) begin
          w_state_next = HZ_RUN;
        end
      end
    end else if (hz.ID_branch || hz.ID_unconditional_jmp) begin
      // The sequentially fetched instruction is on the wrong path.
      w_ifid_flush = 1'b1;
    end
  end

  // FSM state and load-use bubble counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= HZ_RUN;
      r_lu_cnt <= '0;
    end else begin
      r_state  <= w_state_next;
      r_lu_cnt <= w_lu_cnt_next;
    end
  end

  // Carry the prediction of a conditional branch from ID into EX.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ex_valid <= 1'b0;
      r_ex_pred  <= 1'b0;
    end else if (w_idex_flush) begin
      r_ex_valid <= 1'b0;
    end else begin
      r_ex_valid <= hz.ID_branch && !hz.ID_unconditional_jmp;
      r_ex_pred  <= hz.ID_pred_take;
    end
  end

  // Performance counters: 0 = branches, 1 = mispredicts, 2 = stall cycles.
  logic [2:0]       w_cnt_inc;
  logic [CNT_W-1:0] w_cnt [3];

  assign w_cnt_inc = {w_ex_stall, w_mispredict, w_ex_cond};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
      sat_counter #(.W(CNT_W)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .i_clr (hz.perf_clear),
        .i_inc (w_cnt_inc[gi]),
        .o_cnt (w_cnt[gi])
      );
    end
  endgenerate

  assign hz.EX_stall         = w_ex_stall;
  assign hz.IFID_write_en    = w_ifid_we;
  assign hz.IFID_flush       = w_ifid_flush;
  assign hz.IDEX_flush       = w_idex_flush;
  assign hz.mispredict       = w_mispredict;
  assign hz.perf_branch_cnt  = w_cnt[0];
  assign hz.perf_mispred_cnt = w_cnt[1];
  assign hz.perf_stall_cnt   = w_cnt[2];

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: dut_a (1 bubble, 4-bit counters) and
// dut_b (3 bubbles, 32-bit counters) share the same stimulus.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(4))  a_if ();
  pipe_hazard_ctrl_if #(.CNT_W(32)) b_if ();

  pipe_hazard_ctrl #(.CNT_W(4), .LU_STALL_CYCLES(1)) dut_a (
    .clk   (clk),
    .reset (reset),
    .hz    (a_if.slave)
  );

  pipe_hazard_ctrl #(.CNT_W(32), .LU_STALL_CYCLES(3)) dut_b (
    .clk   (clk),
    .reset (reset),
    .hz    (b_if.slave)
  );

  // Expected control word: {EX_stall, IFID_write_en, IFID_flush, IDEX_flush, mispredict}
  localparam logic [4:0] E_IDLE  = 5'b01000;
  localparam logic [4:0] E_STALL = 5'b10010;
  localparam logic [4:0] E_IFF   = 5'b01100;
  localparam logic [4:0] E_MP    = 5'b01111;

  typedef struct {
    logic [4:0] rs1;
    logic       rs1u;
    logic [4:0] rs2;
    logic       rs2u;
    logic       mr;
    logic [4:0] rd;
    logic       idb;
    logic       idj;
    logic       pt;
    logic       exb;
    logic       exj;
    logic       exz;
    logic       rdy;
    logic       clr;
    logic [4:0] exp_ctl;
  } vec_t;

  int checks = 0;
  int failures = 0;
  vec_t sb_q[$];

  function automatic vec_t mk(logic [4:0] rs1, logic rs1u, logic [4:0] rs2, logic rs2u,
                              logic mr, logic [4:0] rd, logic idb, logic idj, logic pt,
                              logic exb, logic exj, logic exz, logic rdy, logic [4:0] e);
    vec_t v;
    v.rs1 = rs1; v.rs1u = rs1u; v.rs2 = rs2; v.rs2u = rs2u;
    v.mr = mr; v.rd = rd; v.idb = idb; v.idj = idj; v.pt = pt;
    v.exb = exb; v.exj = exj; v.exz = exz; v.rdy = rdy; v.clr = 1'b0;
    v.exp_ctl = e;
    return v;
  endfunction

  // Common vectors.
  function automatic vec_t v_idle();
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, E_IDLE);
  endfunction
  function automatic vec_t v_lu(logic [4:0] e);
    return mk(5, 1, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0, 1, e);
  endfunction

  task automatic set_inputs(input vec_t v);
    a_if.ID_rs1 = v.rs1; a_if.ID_rs1_used = v.rs1u; a_if.ID_rs2 = v.rs2; a_if.ID_rs2_used = v.rs2u;
    a_if.EX_mem_read = v.mr; a_if.EX_rd = v.rd; a_if.ID_branch = v.idb;
    a_if.ID_unconditional_jmp = v.idj; a_if.ID_pred_take = v.pt; a_if.EX_branch = v.exb;
    a_if.EX_unconditional_jmp = v.exj; a_if.EX_zero = v.exz; a_if.imem_ready = v.rdy;
    a_if.perf_clear = v.clr;
    b_if.ID_rs1 = v.rs1; b_if.ID_rs1_used = v.rs1u; b_if.ID_rs2 = v.rs2; b_if.ID_rs2_used = v.rs2u;
    b_if.EX_mem_read = v.mr; b_if.EX_rd = v.rd; b_if.ID_branch = v.idb;
    b_if.ID_unconditional_jmp = v.idj; b_if.ID_pred_take = v.pt; b_if.EX_branch = v.exb;
    b_if.EX_unconditional_jmp = v.exj; b_if.EX_zero = v.exz; b_if.imem_ready = v.rdy;
    b_if.perf_clear = v.clr;
  endtask

  function automatic logic [4:0] ctl_a();
    return {a_if.EX_stall, a_if.IFID_write_en, a_if.IFID_flush, a_if.IDEX_flush, a_if.mispredict};
  endfunction
  function automatic logic [4:0] ctl_b();
    return {b_if.EX_stall, b_if.IFID_write_en, b_if.IFID_flush, b_if.IDEX_flush, b_if.mispredict};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Drive one cycle at posedge+1, queue the expectation, compare at negedge,
  // then return at the next posedge+1.
  task automatic step(input vec_t v, input bit use_b, input string name);
    vec_t e;
    logic [4:0] act;
    set_inputs(v);
    sb_q.push_back(v);
    @(negedge clk);
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb_q.pop_front();
      act = use_b ? ctl_b() : ctl_a();
      if (act !== e.exp_ctl) begin
        failures++;
        $display("FAIL %s: ctl got %b expected %b (stall,we,iff,idf,mp)", name, act, e.exp_ctl);
      end else begin
        $display("ok   %s: ctl %b", name, act);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_inputs(v_idle());
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  vec_t tbl[10];
  int   stall_exp;
  vec_t v;

  initial begin
    set_inputs(v_idle());
    #1;
    // Reset state while held in reset.
    chk("reset_ctl_a", 32'(ctl_a()), 32'(E_IDLE));
    chk("reset_ctl_b", 32'(ctl_b()), 32'(E_IDLE));
    chk("reset_stall_cnt_b", b_if.perf_stall_cnt, 0);
    do_reset();

    // Single-cycle decode table on dut_a (1 bubble: FSM stays in RUN).
    tbl[0] = v_idle();
    tbl[1] = v_lu(E_STALL);
    tbl[2] = mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, E_IDLE);   // EX_rd = x0
    tbl[3] = mk(3, 0, 7, 1, 1, 7, 0, 0, 0, 0, 0, 0, 1, E_STALL);  // rs2 hit
    tbl[4] = mk(3, 0, 7, 0, 1, 7, 0, 0, 0, 0, 0, 0, 1, E_IDLE);   // rs2 unused
    tbl[5] = mk(7, 1, 7, 1, 0, 7, 0, 0, 0, 0, 0, 0, 1, E_IDLE);   // not a load
    tbl[6] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_STALL);  // imem wait
    tbl[7] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, E_IFF);    // ID branch
    tbl[8] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, E_IFF);    // ID jump
    tbl[9] = mk(9, 1, 0, 0, 1, 9, 1, 0, 0, 0, 0, 0, 1, E_STALL);  // stall beats redirect
    stall_exp = 0;
    for (int i = 0; i < 10; i++) begin
      step(tbl[i], 1'b0, $sformatf("tbl[%0d]", i));
      if (tbl[i].exp_ctl[4]) stall_exp++;
      chk($sformatf("tbl[%0d]_stall_cnt", i), 32'(a_if.perf_stall_cnt), stall_exp);
    end

    // Branch tracking and mispredict on dut_a.
    do_reset();
    step(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1, E_IFF), 1'b0, "br_taken_id");
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, E_MP), 1'b0, "br_taken_ex_nt");
    chk("mp_cnt_1", 32'(a_if.perf_mispred_cnt), 1);
    chk("br_cnt_1", 32'(a_if.perf_branch_cnt), 1);
    step(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1, E_IFF), 1'b0, "br_ok_id");
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, E_IDLE), 1'b0, "br_ok_ex");
    step(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1, E_IFF), 1'b0, "jmp_id");
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, E_IDLE), 1'b0, "jmp_untracked_ex");
    chk("br_cnt_2", 32'(a_if.perf_branch_cnt), 2);
    chk("mp_cnt_still_1", 32'(a_if.perf_mispred_cnt), 1);
    step(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, E_IFF), 1'b0, "br_nt_id");
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, E_MP), 1'b0, "br_nt_ex_taken");
    chk("mp_cnt_2", 32'(a_if.perf_mispred_cnt), 2);
    chk("br_cnt_3", 32'(a_if.perf_branch_cnt), 3);

    // Mispredict + imem wait + load-use in one cycle on dut_b.
    do_reset();
    step(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1, E_IFF), 1'b1, "triple_id");
    step(mk(5, 1, 0, 0, 1, 5, 0, 0, 0, 1, 0, 0, 0, E_MP), 1'b1, "triple_ex");
    step(v_idle(), 1'b1, "triple_after_run");
    chk("triple_stall_cnt", b_if.perf_stall_cnt, 0);

    // Multi-cycle load-use on dut_b: 3 bubbles, then 3 + 2 imem waits.
    do_reset();
    step(v_lu(E_STALL), 1'b1, "lu3_c1");
    v = v_idle(); v.exp_ctl = E_STALL;
    step(v, 1'b1, "lu3_c2");
    step(v, 1'b1, "lu3_c3");
    step(v_idle(), 1'b1, "lu3_done");
    chk("lu3_stall_cnt", b_if.perf_stall_cnt, 3);
    step(v_lu(E_STALL), 1'b1, "lu5_c1");
    v = v_idle(); v.rdy = 1'b0; v.exp_ctl = E_STALL;
    step(v, 1'b1, "lu5_wait1");
    step(v, 1'b1, "lu5_wait2");
    v = v_idle(); v.exp_ctl = E_STALL;
    step(v, 1'b1, "lu5_c4");
    step(v, 1'b1, "lu5_c5");
    step(v_idle(), 1'b1, "lu5_done");
    chk("lu5_stall_cnt", b_if.perf_stall_cnt, 8);

    // Asynchronous reset in the middle of LU_STALL.
    step(v_lu(E_STALL), 1'b1, "rst_lu_c1");
    set_inputs(v_idle());
    #1;
    chk("rst_in_lu_stall", 32'(ctl_b()), 32'(E_STALL));
    reset = 1'b0;
    #1;
    chk("rst_async_ctl", 32'(ctl_b()), 32'(E_IDLE));
    chk("rst_async_cnt", b_if.perf_stall_cnt, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(v_idle(), 1'b1, "rst_after_idle");

    // Saturation and clear on dut_a (4-bit counters).
    do_reset();
    v = v_idle(); v.rdy = 1'b0; v.exp_ctl = E_STALL;
    for (int i = 0; i < 20; i++) step(v, 1'b0, $sformatf("sat_%0d", i));
    chk("sat_stall_cnt", 32'(a_if.perf_stall_cnt), 15);
    v.clr = 1'b1;
    step(v, 1'b0, "clear_cycle");
    chk("clear_stall_cnt", 32'(a_if.perf_stall_cnt), 0);
    chk("sb_empty", 32'(sb_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
